// File: rtl/option_dispatcher.sv
// option_dispatcher: circular header/option queue feeding the nonogram
// line solver, with drain gaps, pass accounting and stall detection.
module option_dispatcher #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64,
  parameter int DRAIN = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic            load_index,
  input  logic [SIZE-1:0] load_data,
  input  logic            load_done,
  output logic            started,
  output logic [SIZE-1:0] option,
  output logic            valid_op,
  output logic            is_index,
  input  logic            put_back_to_FIFO,
  input  logic [SIZE-1:0] new_option,
  input  logic            solved,
  output logic            done,
  output logic            stuck,
  output logic            overflow,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NL = 2 * SIZE;
  localparam int HW = $clog2(NL + 1);
  localparam int DW = $clog2(DRAIN + 1);
  localparam int EW = SIZE + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAINING,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [EW-1:0] head, push_data;
  logic          push, pop, show, push_ok;
  logic          go_stuck, clr_pass, clr_opt;
  logic          start_n, pb_cnt, opt_pop;
  logic          opt_pend;
  logic [DW-1:0] drain_cnt, drain_n;
  logic [DW-1:0] empty_cnt, empty_n;
  logic [HW-1:0] hdr_cnt, hdr_n;
  logic [6:0]    n_pop, n_put;

  assign head    = mem[rd_ptr];
  assign push_ok = push && (count != CW'(DEPTH) || pop);
  assign opt_pop = pop && !head[SIZE];

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    show      = 1'b0;
    go_stuck  = 1'b0;
    clr_pass  = 1'b0;
    clr_opt   = 1'b0;
    start_n   = 1'b0;
    pb_cnt    = 1'b0;
    drain_n   = drain_cnt;
    empty_n   = '0;
    hdr_n     = hdr_cnt;
    unique case (state)
      S_IDLE: begin
        if (put_back_to_FIFO) begin
          push      = 1'b1;
          push_data = {1'b0, new_option};
        end else if (load_valid) begin
          push      = 1'b1;
          push_data = {load_index, load_data};
        end
        if (load_done) begin
          if (count == '0) begin
            state_n  = S_DONE;
            go_stuck = 1'b1;
          end else begin
            state_n = S_RUN;
            start_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (put_back_to_FIFO) begin
          push      = 1'b1;
          push_data = {1'b0, new_option};
          pb_cnt    = 1'b1;
        end
        if (count == '0) begin
          if (empty_cnt >= DW'(DRAIN - 1)) begin
            state_n  = S_DONE;
            go_stuck = 1'b1;
          end else begin
            empty_n = empty_cnt + DW'(1);
          end
        end else if (!head[SIZE]) begin
          pop  = 1'b1;
          show = 1'b1;
        end else if (opt_pend) begin
          // let the solver's write-backs for this line land first
          state_n = S_DRAINING;
          drain_n = DW'(1);
        end else if (!put_back_to_FIFO) begin
          if (hdr_cnt == '0 && n_pop == n_put && n_pop != '0) begin
            state_n  = S_DONE;
            go_stuck = 1'b1;
          end else begin
            pop       = 1'b1;
            show      = 1'b1;
            push      = 1'b1;
            push_data = head;
            clr_pass  = (hdr_cnt == '0);
            hdr_n     = (hdr_cnt == HW'(NL - 1)) ? '0 : hdr_cnt + HW'(1);
          end
        end
      end
      S_DRAINING: begin
        if (put_back_to_FIFO) begin
          push      = 1'b1;
          push_data = {1'b0, new_option};
          pb_cnt    = 1'b1;
        end
        if (drain_cnt >= DW'(DRAIN - 1)) begin
          state_n = S_RUN;
          clr_opt = 1'b1;
        end else begin
          drain_n = drain_cnt + DW'(1);
        end
      end
      default: ;
    endcase
    if (solved) begin
      state_n  = S_DONE;
      push     = 1'b0;
      pop      = 1'b0;
      show     = 1'b0;
      go_stuck = 1'b0;
      start_n  = 1'b0;
      pb_cnt   = 1'b0;
      clr_pass = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      started   <= 1'b0;
      option    <= '0;
      valid_op  <= 1'b0;
      is_index  <= 1'b0;
      done      <= 1'b0;
      stuck     <= 1'b0;
      overflow  <= 1'b0;
      opt_pend  <= 1'b0;
      drain_cnt <= '0;
      empty_cnt <= '0;
      hdr_cnt   <= '0;
      n_pop     <= '0;
      n_put     <= '0;
    end else begin
      state     <= state_n;
      count     <= count + CW'(push_ok) - CW'(pop);
      started   <= start_n;
      valid_op  <= show;
      option    <= show ? head[SIZE-1:0] : '0;
      is_index  <= show & head[SIZE];
      drain_cnt <= drain_n;
      empty_cnt <= empty_n;
      hdr_cnt   <= hdr_n;
      if (push_ok)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      if (push && !push_ok)
        overflow <= 1'b1;
      if (solved)
        done <= 1'b1;
      if (go_stuck)
        stuck <= 1'b1;
      if (clr_opt)
        opt_pend <= 1'b0;
      else if (opt_pop)
        opt_pend <= 1'b1;
      if (clr_pass) begin
        n_pop <= '0;
        n_put <= '0;
      end else begin
        if (opt_pop && n_pop != 7'd127)
          n_pop <= n_pop + 7'd1;
        if (pb_cnt && n_put != 7'd127)
          n_put <= n_put + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: doc/option_dispatcher.md
Name: option_dispatcher

Overview:
- Option queue and scheduler that feeds the nonogram line solver.
- Holds every line header (line index) and every candidate option in one circular buffer.
- Streams header-then-options to the solver and re-enqueues surviving options returned by the solver on put_back_to_FIFO.
- Detects a solved board and a stalled board (a full pass with no eliminations).

Parameters:
SIZE, 3, board dimension; options are SIZE bits wide; 2*SIZE lines.
DEPTH, 64, queue entries; each entry is {is_index, data[SIZE-1:0]}.
DRAIN, 4, idle cycles inserted before each header pop so the solver's write-backs for the previous line land.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_valid  in  1  write one entry during load
load_index  in  1  entry is a line header; load_data[SIZE-1:0] holds the line index
load_data  in  SIZE  option bits or line index
load_done  in  1  pulse: loading finished
started  out  1  one-cycle pulse entering RUN
option  out  SIZE  entry presented to solver
valid_op  out  1  option/is_index valid this cycle
is_index  out  1  presented entry is a line header
put_back_to_FIFO  in  1  solver returns a surviving option
new_option  in  SIZE  option being returned
solved  in  1  solver reports board solved
done  out  1  sticky: solved seen
stuck  out  1  sticky: pass completed with zero eliminations
overflow  out  1  sticky: push attempted while full and no pop
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: all outputs 0, rd/wr pointers 0, count 0, state IDLE.
- States: IDLE, RUN, DRAINING, DONE.
- IDLE:
  - load_valid pushes {load_index, load_data} at the tail.
  - load_done moves to RUN and pulses started for one cycle.
  - If count==0 at load_done, go to DONE with stuck=1 instead.
- RUN, pop rules:
  - One pop per cycle when count>0. Outputs are registered; the entry appears on option/is_index with valid_op=1 the cycle after the pop.
  - Popped option entries are not re-pushed by the dispatcher. The solver alone decides survival via put_back_to_FIFO.
  - Popped header entries are re-pushed at the tail in the same cycle (rotation), so count is unchanged.
  - Before popping a header, if any option was popped since the previous header, go to DRAINING for DRAIN cycles (valid_op=0), then pop the header and return to RUN.
- Push priority:
  - put_back_to_FIFO pushes {0,new_option} at the tail in any state except DONE.
  - If a header re-push and a put_back coincide, put_back wins and the header pop is deferred one cycle (no pop that cycle).
- Pass and stuck detection:
  - A pass is 2*SIZE header pops.
  - Per pass, count options_popped and put_backs received (7-bit counters, saturating at 127).
  - At the header pop that starts a new pass: if options_popped==put_backs and options_popped>0, set stuck and go to DONE. Either way, clear both counters.
- Full boundary:
  - A push with count==DEPTH and no pop in the same cycle is dropped and sets overflow.
  - Simultaneous push and pop at full is legal; count stays DEPTH.
- Empty boundary: count==0 in RUN means valid_op=0 and no pop. If this persists through DRAIN cycles, set stuck and go to DONE.
- Pointers wrap modulo DEPTH.
- solved=1 in any state: set done, go to DONE. In DONE, valid_op=0, pushes are ignored, and only rst exits.
- rst mid-operation: immediate return to reset values; queue contents are discarded logically (count=0).

Test Plan:
- Load SIZE=3: header 0, options 3'b101, 3'b011, then load_done -> started pulses 1 cycle; next cycles present {is_index=1,0}, then 101, then 011 with valid_op=1; count stays 3 after the header rotation.
- Solver returns 101 only (011 contradicted) -> after DRAIN=4 idle cycles the header 0 is re-presented, followed by 101 only; count=2.
- All 6 headers plus one option each, every option put back for a full pass -> stuck=1, DONE, valid_op=0 thereafter.
- Fill to DEPTH=64, then put_back with no pop -> overflow=1 and count=64; put_back coinciding with a pop at full -> no overflow, count=64.
- put_back in the same cycle a header is due -> put_back stored first, header popped the following cycle, no entry lost.
- solved=1 mid-stream -> done=1 next cycle, valid_op=0; rst during RUN -> count=0, all outputs 0, state IDLE.
